// File: rtl/rxuart_param_if.sv
// Serial-line side of one receive channel: RX pin in, decoded word and status out.
// slave = receiver, master = line driver / command decoder.
interface rxuart_param_if #(
  parameter int DATA_BITS = 8
);
  // o_rx_valid is a one-cycle pulse with no ready. Data and both error flags are
  // meaningful only while it is high. The consumer must take the word on that cycle.
  logic                 i_uart_rx;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_break;
  logic                 o_busy;
  logic [2:0]           o_state;

  modport slave (
    input  i_uart_rx,
    output o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_break, o_busy, o_state
  );

  modport master (
    output i_uart_rx,
    input  o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_break, o_busy, o_state
  );
endinterface

// File: rtl/rxuart_param.sv
// Parametrised UART receiver with 2-flop synchroniser, framing-error and break detect.
// Optional parity bit between data and stop bits when RXUART_PARITY_EN is defined.
module rxuart_param #(
  parameter int CLOCK_RATE_HZ = 25_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int CLKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rxuart_param_if.slave  io
);

  localparam int             CW      = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0]  C_LAST  = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0]  C_HALF  = CW'((CLKS_PER_BAUD - 1) / 2);
  localparam logic [3:0]     C_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     C_SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RXUART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_count;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_perr, r_brk;

  logic w_rx_s;
  logic w_brk_cond;
  logic w_par_err;

  assign w_rx_s = r_sync2;

`ifdef RXUART_PARITY_EN
  localparam logic C_ODD = (PARITY_ODD != 0);
  logic r_par_bit;
  assign w_brk_cond = (r_shift == '0) && !r_par_bit && !w_rx_s;
  assign w_par_err  = (^r_shift) ^ C_ODD ^ r_par_bit;
`else
  assign w_brk_cond = (r_shift == '0) && !w_rx_s;
  assign w_par_err  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_count    <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_stop_err <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_brk      <= 1'b0;
`ifdef RXUART_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_sync1 <= io.i_uart_rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_brk   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (!w_rx_s) r_state <= S_START;
        end

        // Re-check the start bit half a bit in; a high line here is a glitch.
        S_START: begin
          if (r_count == C_HALF) begin
            r_count <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_DATA: begin
          if (r_count == C_LAST) begin
            r_count <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == C_DLAST) begin
              r_idx      <= '0;
              r_stop_err <= 1'b0;
`ifdef RXUART_PARITY_EN
              r_state    <= S_PARITY;
`else
              r_state    <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

`ifdef RXUART_PARITY_EN
        S_PARITY: begin
          if (r_count == C_LAST) begin
            r_count   <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
`endif

        // Leave on the last stop sample (mid-bit) so a following start bit is not missed.
        S_STOP: begin
          if (r_count == C_LAST) begin
            r_count <= '0;
            if (r_idx == 4'd0 && w_brk_cond) begin
              r_state <= S_BREAK;
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_ferr  <= 1'b1;
              r_perr  <= w_par_err;
              r_brk   <= 1'b1;
            end else if (r_idx == C_SLAST) begin
              r_state <= S_IDLE;
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_ferr  <= r_stop_err | !w_rx_s;
              r_perr  <= w_par_err;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_stop_err <= r_stop_err | !w_rx_s;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_BREAK: begin
          r_count <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.o_rx_data    = r_data;
  assign io.o_rx_valid   = r_valid;
  assign io.o_frame_err  = r_ferr;
  assign io.o_parity_err = r_perr;
  assign io.o_break      = r_brk;
  assign io.o_busy       = (r_state != S_IDLE);
  assign io.o_state      = r_state;

endmodule

// File: tb/tb_rxuart_param.sv
// Directed bench for rxuart_param: an 8N1 channel and a 7-bit, 2-stop channel
// (odd parity when RXUART_PARITY_EN is defined).
module tb_rxuart_param;

  localparam int CPB = 25_000_000 / 115_200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rxuart_param_if #(.DATA_BITS(8)) if_a ();
  rxuart_param_if #(.DATA_BITS(7)) if_b ();

  rxuart_param #(.DATA_BITS(8)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .io      (if_a)
  );

  rxuart_param #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .io      (if_b)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } cap_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_a_t;

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       s2;
    logic [6:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_b_t;

  cap_t cap_a[$];
  cap_t cap_b[$];
  int   total = 0;
  int   bad = 0;
  int   qual_viol = 0;
  int   brk_alone = 0;

  // Scoreboard capture: every valid pulse is one queue entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_a.o_rx_valid)
        cap_a.push_back({1'b0, if_a.o_rx_data, if_a.o_frame_err, if_a.o_parity_err, if_a.o_break});
      if (if_b.o_rx_valid)
        cap_b.push_back({2'b0, if_b.o_rx_data, if_b.o_frame_err, if_b.o_parity_err, if_b.o_break});
      if (!if_a.o_rx_valid && (if_a.o_frame_err || if_a.o_parity_err)) qual_viol++;
      if (!if_b.o_rx_valid && (if_b.o_frame_err || if_b.o_parity_err)) qual_viol++;
      if (if_a.o_break && !if_a.o_rx_valid) brk_alone++;
      if (if_b.o_break && !if_b.o_rx_valid) brk_alone++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic line(input int which, input logic b);
    if (which == 0) if_a.i_uart_rx = b;
    else            if_b.i_uart_rx = b;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int npar, input logic par, input logic s1,
                            input logic s2, input int nstop, input int gap);
    logic [8:0] d;
    d = data;
    line(which, 1'b0);
    hold_bits(1);
    for (int i = 0; i < nbits; i++) begin
      line(which, d[0]);
      d = d >> 1;
      hold_bits(1);
    end
    if (npar != 0) begin
      line(which, par);
      hold_bits(1);
    end
    line(which, s1);
    hold_bits(1);
    if (nstop == 2) begin
      line(which, s2);
      hold_bits(1);
    end
    if (gap > 0) begin
      line(which, 1'b1);
      hold_bits(gap);
    end
  endtask

  task automatic expect_a(input string name, input logic [7:0] data,
                          input logic ferr, input logic brk);
    cap_t c;
    c = (cap_a.size() > 0) ? cap_a.pop_front() : '1;
    check({name, "_data"}, 32'(c.data), 32'(data));
    check({name, "_ferr"}, 32'(c.ferr), 32'(ferr));
    check({name, "_brk"},  32'(c.brk),  32'(brk));
    check({name, "_perr"}, 32'(c.perr), 32'd0);
  endtask

  vec_a_t va[6];
  vec_b_t vb[3];
  int     busy_n;
  int     npar_b;

  initial begin
    va[0] = '{8'hA5, 1'b1, 2, 8'hA5, 1'b0};
    va[1] = '{8'h3C, 1'b0, 0, 8'h3C, 1'b1};
    va[2] = '{8'h5A, 1'b1, 2, 8'h5A, 1'b0};
    va[3] = '{8'h00, 1'b1, 2, 8'h00, 1'b0};
    va[4] = '{8'hFF, 1'b1, 2, 8'hFF, 1'b0};
    va[5] = '{8'hA5, 1'b1, 2, 8'hA5, 1'b0};
`ifdef RXUART_PARITY_EN
    npar_b = 1;
    vb[0] = '{7'h55, 1'b1, 1'b1, 7'h55, 1'b0, 1'b0};
    vb[1] = '{7'h07, 1'b1, 1'b1, 7'h07, 1'b0, 1'b1};
    vb[2] = '{7'h55, 1'b1, 1'b0, 7'h55, 1'b1, 1'b0};
`else
    npar_b = 0;
    vb[0] = '{7'h55, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0};
    vb[1] = '{7'h07, 1'b0, 1'b1, 7'h07, 1'b0, 1'b0};
    vb[2] = '{7'h55, 1'b0, 1'b0, 7'h55, 1'b1, 1'b0};
`endif

    if_a.i_uart_rx = 1'b1;
    if_b.i_uart_rx = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data",  32'(if_a.o_rx_data),    32'd0);
    check("rst_valid", 32'(if_a.o_rx_valid),   32'd0);
    check("rst_ferr",  32'(if_a.o_frame_err),  32'd0);
    check("rst_perr",  32'(if_a.o_parity_err), 32'd0);
    check("rst_brk",   32'(if_a.o_break),      32'd0);
    check("rst_busy",  32'(if_a.o_busy),       32'd0);
    check("rst_state", 32'(if_a.o_state),      32'd0);
    check("rst_b_data", 32'(if_b.o_rx_data),   32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Table: normal frames, a framing error followed back-to-back by a good frame.
    for (int i = 0; i < 6; i++)
      send_frame(0, {1'b0, va[i].data}, 8, 0, 1'b0, va[i].stop, 1'b1, 1, va[i].gap);
    hold_bits(2);
    check("tbl_count", 32'(cap_a.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      expect_a($sformatf("tbl%0d", i), va[i].exp_data, va[i].exp_ferr, 1'b0);

    repeat (1000) @(posedge clk);
    #1;
    check("hold_data", 32'(if_a.o_rx_data), 32'hA5);
    check("hold_nopulse", 32'(cap_a.size()), 32'd0);

    // 50-cycle low glitch: START runs half a bit, then gives up.
    busy_n = 0;
    line(0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      if (c == 50) line(0, 1'b1);
      @(posedge clk);
      #1;
      if (if_a.o_busy) busy_n++;
    end
    check("glitch_busy_len", 32'((busy_n >= 100) && (busy_n <= 120)), 32'd1);
    check("glitch_idle", 32'(if_a.o_busy), 32'd0);
    check("glitch_nopulse", 32'(cap_a.size()), 32'd0);

    // Break: 12 bit times low.
    line(0, 1'b0);
    hold_bits(12);
    check("brk_count", 32'(cap_a.size()), 32'd1);
    expect_a("brk", 8'h00, 1'b1, 1'b1);
    check("brk_busy", 32'(if_a.o_busy), 32'd1);
    line(0, 1'b1);
    hold_bits(2);
    check("brk_after_nopulse", 32'(cap_a.size()), 32'd0);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1, 2);
    check("post_brk_count", 32'(cap_a.size()), 32'd1);
    expect_a("post_brk", 8'h81, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0xF0.
    line(0, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      line(0, 1'b0);
      hold_bits(1);
    end
    line(0, 1'b1);
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_data",  32'(if_a.o_rx_data), 32'd0);
    check("mid_rst_busy",  32'(if_a.o_busy),    32'd0);
    check("mid_rst_valid", 32'(if_a.o_rx_valid), 32'd0);
    hold_bits(4);
    check("mid_rst_nopulse", 32'(cap_a.size()), 32'd0);
    send_frame(0, 9'h012, 8, 0, 1'b0, 1'b1, 1'b1, 1, 2);
    check("post_rst_count", 32'(cap_a.size()), 32'd1);
    expect_a("post_rst", 8'h12, 1'b0, 1'b0);

    // 7-bit, 2-stop channel.
    for (int i = 0; i < 3; i++)
      send_frame(1, {2'b0, vb[i].data}, 7, npar_b, vb[i].par, 1'b1, vb[i].s2, 2, 2);
    check("b_count", 32'(cap_b.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      cap_t c;
      c = (cap_b.size() > 0) ? cap_b.pop_front() : '1;
      check($sformatf("b%0d_data", i), 32'(c.data), 32'(vb[i].exp_data));
      check($sformatf("b%0d_ferr", i), 32'(c.ferr), 32'(vb[i].exp_ferr));
      check($sformatf("b%0d_perr", i), 32'(c.perr), 32'(vb[i].exp_perr));
      check($sformatf("b%0d_brk", i),  32'(c.brk),  32'd0);
    end

    check("flag_qualify", 32'(qual_viol), 32'd0);
    check("break_alone",  32'(brk_alone), 32'd0);
    check("a_no_extra",   32'(cap_a.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
